// File: rtl/usb_cmd_parser.sv
// usb_cmd_parser: framed command decoder between the USB FIFO receiver and
// the waveform generator. Frames are AA, OP, P0, P1, CK with CK = OP^P0^P1.
// Good frames update the registered control outputs. Bad or stalled frames
// are dropped and reported on err/err_code.
module usb_cmd_parser #(
    parameter logic [4:0]  DEF_STATE = 5'd4,
    parameter logic [11:0] DEF_FREQ  = 12'd1,
    parameter logic [15:0] TIMEOUT   = 16'd50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [4:0]  state,
    output logic [11:0] state_freq,
    output logic [2:0]  state_amp,
    output logic [7:0]  state_phase,
    output logic        upd,
    output logic        err,
    output logic [1:0]  err_code,
    output logic [7:0]  frame_cnt
);

    localparam logic [7:0] HDR = 8'hAA;

    typedef enum logic [2:0] {
        S_IDLE,
        S_OPC,
        S_PL0,
        S_PL1,
        S_CHK
    } fsm_t;

    fsm_t        r_fsm;
    logic [15:0] r_idle;
    logic [7:0]  r_op;
    logic [7:0]  r_p0;
    logic [7:0]  r_p1;
    logic [4:0]  r_state;
    logic [11:0] r_freq;
    logic [2:0]  r_amp;
    logic [7:0]  r_phase;
    logic        r_upd;
    logic        r_err;
    logic [1:0]  r_code;
    logic [7:0]  r_cnt;

    logic        w_take;
    logic        w_ck_ok;

    // The parser never back-pressures; it only refuses bytes while held in reset.
    assign rx_ready = ~rst;
    assign w_take   = rx_valid & rx_ready;
    assign w_ck_ok  = (rx_data == (r_op ^ r_p0 ^ r_p1));

    assign state       = r_state;
    assign state_freq  = r_freq;
    assign state_amp   = r_amp;
    assign state_phase = r_phase;
    assign upd         = r_upd;
    assign err         = r_err;
    assign err_code    = r_code;
    assign frame_cnt   = r_cnt;

    // Shadow registers capture the frame body; they are pure data and need no reset.
    always_ff @(posedge clk) begin
        if (w_take) begin
            case (r_fsm)
                S_OPC:   r_op <= rx_data;
                S_PL0:   r_p0 <= rx_data;
                S_PL1:   r_p1 <= rx_data;
                default: ;
            endcase
        end
    end

    // Frame FSM, idle timeout, and the registered control outputs it commits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fsm   <= S_IDLE;
            r_idle  <= 16'd0;
            r_state <= DEF_STATE;
            r_freq  <= DEF_FREQ;
            r_amp   <= 3'd0;
            r_phase <= 8'd0;
            r_upd   <= 1'b0;
            r_err   <= 1'b0;
            r_code  <= 2'd0;
            r_cnt   <= 8'd0;
        end else begin
            r_upd <= 1'b0;
            r_err <= 1'b0;
            if (w_take) begin
                // An accepted byte always wins over a timeout expiring this cycle.
                r_idle <= 16'd0;
                case (r_fsm)
                    S_IDLE: if (rx_data == HDR) r_fsm <= S_OPC;
                    S_OPC:  r_fsm <= S_PL0;
                    S_PL0:  r_fsm <= S_PL1;
                    S_PL1:  r_fsm <= S_CHK;
                    S_CHK: begin
                        r_fsm <= S_IDLE;
                        if (!w_ck_ok) begin
                            r_err  <= 1'b1;
                            r_code <= 2'd1;
                        end else begin
                            case (r_op)
                                8'h01: begin
                                    r_state <= r_p1[4:0];
                                    r_upd   <= 1'b1;
                                    r_cnt   <= r_cnt + 8'd1;
                                end
                                8'h02: begin
                                    r_freq <= {r_p0[3:0], r_p1};
                                    r_upd  <= 1'b1;
                                    r_cnt  <= r_cnt + 8'd1;
                                end
                                8'h03: begin
                                    r_amp <= r_p1[2:0];
                                    r_upd <= 1'b1;
                                    r_cnt <= r_cnt + 8'd1;
                                end
                                8'h04: begin
                                    r_phase <= r_p1;
                                    r_upd   <= 1'b1;
                                    r_cnt   <= r_cnt + 8'd1;
                                end
                                default: begin
                                    r_err  <= 1'b1;
                                    r_code <= 2'd2;
                                end
                            endcase
                        end
                    end
                    default: r_fsm <= S_IDLE;
                endcase
            end else if (r_fsm != S_IDLE) begin
                // Stalled mid-frame: drop the partial frame once the gap hits the limit.
                if (r_idle == TIMEOUT - 16'd1) begin
                    r_fsm  <= S_IDLE;
                    r_idle <= 16'd0;
                    r_err  <= 1'b1;
                    r_code <= 2'd3;
                end else begin
                    r_idle <= r_idle + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_usb_cmd_parser.sv
// Self-checking bench for usb_cmd_parser: directed frames from the test plan
// plus randomized byte streams, compared every cycle against a frame-level model.
module tb_usb_cmd_parser;

    localparam int TO = 40;

    logic        clk;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [4:0]  state;
    logic [11:0] state_freq;
    logic [2:0]  state_amp;
    logic [7:0]  state_phase;
    logic        upd;
    logic        err;
    logic [1:0]  err_code;
    logic [7:0]  frame_cnt;

    int n_checks = 0;
    int n_errors = 0;

    usb_cmd_parser #(
        .DEF_STATE (5'd4),
        .DEF_FREQ  (12'd1),
        .TIMEOUT   (16'(TO))
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .state       (state),
        .state_freq  (state_freq),
        .state_amp   (state_amp),
        .state_phase (state_phase),
        .upd         (upd),
        .err         (err),
        .err_code    (err_code),
        .frame_cnt   (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the frame in progress as a byte list plus an idle-gap count.
    logic [7:0]  m_q[$];
    int          m_gap;
    logic [4:0]  m_state;
    logic [11:0] m_freq;
    logic [2:0]  m_amp;
    logic [7:0]  m_phase;
    logic        m_upd;
    logic        m_err;
    logic [1:0]  m_code;
    logic [7:0]  m_cnt;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_gap   = 0;
        m_state = 5'd4;
        m_freq  = 12'd1;
        m_amp   = 3'd0;
        m_phase = 8'd0;
        m_upd   = 1'b0;
        m_err   = 1'b0;
        m_code  = 2'd0;
        m_cnt   = 8'd0;
    endtask

    task automatic model_frame();
        logic [7:0] op, p0, p1, ck;
        op = m_q[1]; p0 = m_q[2]; p1 = m_q[3]; ck = m_q[4];
        if (ck != (op ^ p0 ^ p1)) begin
            m_err = 1'b1; m_code = 2'd1;
        end else if (op >= 8'h01 && op <= 8'h04) begin
            if (op == 8'h01) m_state = p1[4:0];
            if (op == 8'h02) m_freq  = {p0[3:0], p1};
            if (op == 8'h03) m_amp   = p1[2:0];
            if (op == 8'h04) m_phase = p1;
            m_upd = 1'b1;
            m_cnt = m_cnt + 8'd1;
        end else begin
            m_err = 1'b1; m_code = 2'd2;
        end
    endtask

    task automatic model_step(input logic v, input logic [7:0] d);
        m_upd = 1'b0;
        m_err = 1'b0;
        if (v) begin
            m_gap = 0;
            if (m_q.size() == 0) begin
                if (d == 8'hAA) m_q.push_back(d);
            end else begin
                m_q.push_back(d);
                if (m_q.size() == 5) begin
                    model_frame();
                    m_q.delete();
                end
            end
        end else if (m_q.size() != 0) begin
            m_gap++;
            if (m_gap == TO) begin
                m_err  = 1'b1;
                m_code = 2'd3;
                m_q.delete();
                m_gap  = 0;
            end
        end
    endtask

    task automatic check_all();
        check_val("rx_ready", 32'(rx_ready), 32'd1);
        check_val("state", 32'(state), 32'(m_state));
        check_val("state_freq", 32'(state_freq), 32'(m_freq));
        check_val("state_amp", 32'(state_amp), 32'(m_amp));
        check_val("state_phase", 32'(state_phase), 32'(m_phase));
        check_val("upd", 32'(upd), 32'(m_upd));
        check_val("err", 32'(err), 32'(m_err));
        check_val("err_code", 32'(err_code), 32'(m_code));
        check_val("frame_cnt", 32'(frame_cnt), 32'(m_cnt));
    endtask

    // One clock cycle with optional byte; outputs sampled 1 time unit after the edge.
    task automatic step(input logic v, input logic [7:0] d);
        rx_valid = v;
        rx_data  = v ? d : 8'($urandom);
        @(posedge clk);
        model_step(v, d);
        #1;
        check_all();
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00);
    endtask

    task automatic send_frame(input logic [7:0] op, input logic [7:0] p0, input logic [7:0] p1,
                              input logic [7:0] ck, input int gap_max);
        logic [7:0] b[5];
        b[0] = 8'hAA; b[1] = op; b[2] = p0; b[3] = p1; b[4] = ck;
        for (int i = 0; i < 5; i++) begin
            if (gap_max > 0) idle($urandom_range(gap_max));
            step(1'b1, b[i]);
        end
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        #1;
        check_val("rst_rx_ready", 32'(rx_ready), 32'd0);
        check_val("rst_state", 32'(state), 32'd4);
        check_val("rst_freq", 32'(state_freq), 32'd1);
        check_val("rst_amp", 32'(state_amp), 32'd0);
        check_val("rst_phase", 32'(state_phase), 32'd0);
        check_val("rst_err", 32'(err), 32'd0);
        check_val("rst_code", 32'(err_code), 32'd0);
        check_val("rst_cnt", 32'(frame_cnt), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
    endtask

    initial begin
        logic [7:0] op, p0, p1, ck;
        int kind;
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        model_reset();
        repeat (2) @(posedge clk);
        do_reset();

        // Frequency frame back-to-back.
        send_frame(8'h02, 8'h03, 8'hE8, 8'hE9, 0);
        check_val("freq_3e8", 32'(state_freq), 32'h3E8);
        check_val("freq_upd", 32'(upd), 32'd1);
        check_val("freq_cnt", 32'(frame_cnt), 32'd1);
        check_val("freq_state_def", 32'(state), 32'd4);
        step(1'b0, 8'h00);
        check_val("upd_low", 32'(upd), 32'd0);

        // Two frames back-to-back.
        send_frame(8'h01, 8'h00, 8'h07, 8'h06, 0);
        check_val("state_7", 32'(state), 32'd7);
        send_frame(8'h04, 8'h00, 8'h80, 8'h84, 0);
        check_val("phase_80", 32'(state_phase), 32'h80);

        // Bad checksum then unknown opcode.
        send_frame(8'h03, 8'h00, 8'h05, 8'h00, 0);
        check_val("ck_err", 32'(err), 32'd1);
        check_val("ck_code", 32'(err_code), 32'd1);
        check_val("ck_amp", 32'(state_amp), 32'd0);
        send_frame(8'h09, 8'h00, 8'h00, 8'h09, 0);
        check_val("op_err", 32'(err), 32'd1);
        check_val("op_code", 32'(err_code), 32'd2);

        // Garbage before a header is discarded silently.
        step(1'b1, 8'h11);
        step(1'b1, 8'h22);
        check_val("garbage_err", 32'(err), 32'd0);
        send_frame(8'h03, 8'h00, 8'h05, 8'h06, 0);
        check_val("amp_5", 32'(state_amp), 32'd5);

        // Timeout after a partial frame, then recovery.
        step(1'b1, 8'hAA);
        step(1'b1, 8'h01);
        idle(TO - 1);
        check_val("to_not_yet", 32'(err), 32'd0);
        step(1'b0, 8'h00);
        check_val("to_err", 32'(err), 32'd1);
        check_val("to_code", 32'(err_code), 32'd3);
        send_frame(8'h03, 8'h00, 8'h02, 8'h01, 0);
        check_val("to_recover_amp", 32'(state_amp), 32'd2);

        // A byte landing on the expiry cycle is consumed normally.
        step(1'b1, 8'hAA);
        step(1'b1, 8'h01);
        idle(TO - 1);
        step(1'b1, 8'h00);
        check_val("edge_no_err", 32'(err), 32'd0);
        step(1'b1, 8'h06);
        step(1'b1, 8'h07);
        check_val("edge_state_6", 32'(state), 32'd6);

        // frame_cnt wrap over 256 good frames.
        do_reset();
        for (int i = 0; i < 256; i++) begin
            p1 = 8'($urandom);
            send_frame(8'h04, 8'h00, p1, 8'h04 ^ p1, 0);
        end
        check_val("wrap_cnt", 32'(frame_cnt), 32'd0);
        check_val("wrap_upd", 32'(upd), 32'd1);

        // Reset in the middle of a frame.
        step(1'b1, 8'hAA);
        step(1'b1, 8'h01);
        step(1'b1, 8'h00);
        do_reset();
        step(1'b1, 8'h05);
        check_val("post_rst_err", 32'(err), 32'd0);

        // Randomized streams of good, bad and partial frames with gaps.
        for (int n = 0; n < 300; n++) begin
            kind = $urandom_range(9);
            op = 8'($urandom_range(4, 1));
            p0 = 8'($urandom);
            p1 = 8'($urandom);
            ck = op ^ p0 ^ p1;
            case (kind)
                0, 1, 2, 3: send_frame(op, p0, p1, ck, $urandom_range(3));
                4:          send_frame(op, p0, p1, ck ^ 8'(1 << $urandom_range(7)), 1);
                5:          send_frame(8'($urandom_range(255, 5)), p0, p1, 8'($urandom_range(255, 5)) ^ p0 ^ p1, 1);
                6:          step(1'b1, 8'($urandom));
                7: begin
                    step(1'b1, 8'hAA);
                    step(1'b1, op);
                    idle(TO - 2 + $urandom_range(3));
                end
                8:          send_frame(op, 8'hAA, 8'hAA, op, 0);
                default:    idle($urandom_range(4));
            endcase
        end
        idle(TO + 2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
